// File: rtl/mc_iomem_ctrl.sv
// mc_iomem_ctrl: single-port access controller for a small data RAM and a
// bank of memory-mapped I/O ports.
//
// Address map (byte address; bits [1:0] and [31:8] ignored):
//   addr[7]=0 : RAM word addr[log2(DEPTH)+1:2]
//   addr[7]=1 : I/O index addr[6:2]
//               reads : 0..N_IN-1 -> synchronised in_port,
//                       N_IN..N_IN+N_OUT-1 -> out_port read-back
//               writes: 0..N_OUT-1 -> out_port
//               any other index sets the sticky err flag
//
// Ports:
//   clock_i     clock, all state on rising edge
//   reset_i     asynchronous active-high reset
//   req_i       access request (sampled in IDLE only)
//   we_i        1 = write, 0 = read
//   addr_i      byte address
//   wdata_i     write data
//   wstrb_i     byte strobes (only with MC_IOMEM_WSTRB_EN defined)
//   rdata_o     read data, valid while ready_o=1, held otherwise
//   ready_o     one-cycle completion pulse
//   err_o       sticky out-of-range I/O access flag
//   in_port_i   N_IN packed input ports
//   out_port_o  N_OUT packed registered output ports
//
// Build option: define MC_IOMEM_WSTRB_EN to add per-byte write strobes.

module mc_iomem_ctrl #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned N_IN    = 2,
   parameter int unsigned N_OUT   = 2,
   parameter int unsigned RD_WAIT = 1
) (
   input  logic                      clock_i,
   input  logic                      reset_i,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [31:0]               addr_i,
   input  logic [DATA_W-1:0]         wdata_i,
`ifdef MC_IOMEM_WSTRB_EN
   input  logic [DATA_W/8-1:0]       wstrb_i,
`endif
   output logic [DATA_W-1:0]         rdata_o,
   output logic                      ready_o,
   output logic                      err_o,
   input  logic [N_IN*DATA_W-1:0]    in_port_i,
   output logic [N_OUT*DATA_W-1:0]   out_port_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic [2:0]                wcnt_q, wcnt_d;
   logic [5:0]                addr_q, addr_d;
   logic [DATA_W-1:0]         rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic [N_OUT*DATA_W-1:0]   out_q, out_d;
   logic [N_IN*DATA_W-1:0]    sync1_q, sync2_q;
   logic [DATA_W-1:0]         ram_q [DEPTH];

   logic                      accept, capture, rd_oor;
   logic [5:0]                cur_addr;
   logic [31:0]               idx_n;
   logic [AW-1:0]             ram_idx;
   logic [DATA_W-1:0]         rd_val, bmask;
   logic                      unused_addr;

   assign unused_addr = ^{addr_i[31:8], addr_i[1:0]};

`ifdef MC_IOMEM_WSTRB_EN
   always_comb begin
      bmask = '0;
      for (int unsigned b = 0; b < DATA_W/8; b++) begin
         bmask[b*8 +: 8] = {8{wstrb_i[b]}};
      end
   end
`else
   assign bmask = '1;
`endif

   // Writes commit on the accepting edge straight from the inputs, so only
   // the address needs to be held for reads that pass through WAIT.
   assign accept   = (state_q == S_IDLE) && req_i;
   assign cur_addr = (state_q == S_IDLE) ? addr_i[7:2] : addr_q;
   assign idx_n    = {27'd0, cur_addr[4:0]};
   assign ram_idx  = cur_addr[AW-1:0];

   always_comb begin
      rd_val = '0;
      rd_oor = 1'b0;
      if (cur_addr[5]) begin
         if (idx_n >= N_IN + N_OUT) rd_oor = 1'b1;
         for (int unsigned i = 0; i < N_IN; i++) begin
            if (idx_n == i) rd_val = sync2_q[i*DATA_W +: DATA_W];
         end
         for (int unsigned i = 0; i < N_OUT; i++) begin
            if (idx_n == N_IN + i) rd_val = out_q[i*DATA_W +: DATA_W];
         end
      end else begin
         rd_val = ram_q[ram_idx];
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      out_d   = out_q;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               addr_d = addr_i[7:2];
               if (we_i) begin
                  state_d = S_DONE;
                  if (addr_i[7]) begin
                     if (idx_n >= N_OUT) err_d = 1'b1;
                     for (int unsigned i = 0; i < N_OUT; i++) begin
                        if (idx_n == i) begin
                           out_d[i*DATA_W +: DATA_W] =
                              (out_q[i*DATA_W +: DATA_W] & ~bmask) | (wdata_i & bmask);
                        end
                     end
                  end
               end else if (RD_WAIT == 0) begin
                  state_d = S_DONE;
                  capture = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  wcnt_d  = 3'(RD_WAIT - 1);
               end
            end
         end
         S_WAIT: begin
            if (wcnt_q == 3'd0) begin
               state_d = S_DONE;
               capture = 1'b1;
            end else begin
               wcnt_d = wcnt_q - 3'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (capture) begin
         rdata_d = rd_val;
         if (rd_oor) err_d = 1'b1;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         addr_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         out_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         out_q   <= out_d;
         sync1_q <= in_port_i;
         sync2_q <= sync1_q;
      end
   end

   // RAM has no reset; the reset gate keeps a request held during reset
   // from writing.
   always_ff @(posedge clock_i) begin
      if (!reset_i && accept && we_i && !addr_i[7]) begin
         ram_q[ram_idx] <= (ram_q[ram_idx] & ~bmask) | (wdata_i & bmask);
      end
   end

   assign rdata_o    = rdata_q;
   assign ready_o    = (state_q == S_DONE);
   assign err_o      = err_q;
   assign out_port_o = out_q;

endmodule

// File: tb/tb_mc_iomem_ctrl.sv
// Directed bench for mc_iomem_ctrl with default parameters (RD_WAIT=1).

module tb_mc_iomem_ctrl;

   localparam int DW = 32;
   localparam int NI = 2;
   localparam int NO = 2;
   localparam int RW = 1;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              req   = 1'b0;
   logic              we    = 1'b0;
   logic [31:0]       addr  = '0;
   logic [DW-1:0]     wdata = '0;
   logic [NI*DW-1:0]  in_port = '0;
   logic [DW-1:0]     rdata;
   logic              ready;
   logic              err;
   logic [NO*DW-1:0]  out_port;
`ifdef MC_IOMEM_WSTRB_EN
   logic [DW/8-1:0]   wstrb = '1;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   mc_iomem_ctrl #(
      .DATA_W  (DW),
      .DEPTH   (32),
      .N_IN    (NI),
      .N_OUT   (NO),
      .RD_WAIT (RW)
   ) dut (
      .clock_i    (clock),
      .reset_i    (reset),
      .req_i      (req),
      .we_i       (we),
      .addr_i     (addr),
      .wdata_i    (wdata),
`ifdef MC_IOMEM_WSTRB_EN
      .wstrb_i    (wstrb),
`endif
      .rdata_o    (rdata),
      .ready_o    (ready),
      .err_o      (err),
      .in_port_i  (in_port),
      .out_port_o (out_port)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Starts at a negedge, ends at a negedge with the bus idle again.
   task automatic access(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd,
                         output logic [63:0] out_acc);
      int lat;
      int exp_lat;
      lat     = 0;
      exp_lat = w ? 1 : RW + 1;
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clock);
      #1;
      out_acc = out_port;
      // scramble inputs: the access must use what was latched
      req = 1'b0; we = 1'b0; addr = 32'h0000_00FC; wdata = 32'h0BAD_0BAD;
      while (lat < 20) begin
         @(negedge clock);
         lat++;
         if (ready) break;
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      rd = rdata;
      @(negedge clock);
      check({tag, "_pulse"}, 64'(ready), 64'd0);
   endtask

   logic [31:0] rd;
   logic [63:0] oa;

   initial begin
      repeat (3) @(negedge clock);
      check("rst_ready", 64'(ready), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_err",   64'(err),   64'd0);
      check("rst_out",   out_port,   64'd0);
      reset = 1'b0;
      @(negedge clock);

      // RAM write then read-back
      access("wr10", 1'b1, 32'h10, 32'hDEADBEEF, rd, oa);
      check("wr10_rdata_kept", 64'(rd), 64'd0);
      access("rd10", 1'b0, 32'h10, 32'h0, rd, oa);
      check("rd10_data", 64'(rd), 64'hDEADBEEF);
      access("wr14", 1'b1, 32'h14, 32'hA5A50001, rd, oa);
      access("wr7c", 1'b1, 32'h7C, 32'h0BADF00D, rd, oa);
      access("rd7c", 1'b0, 32'h7C, 32'h0, rd, oa);
      check("rd7c_data", 64'(rd), 64'h0BADF00D);
      access("rdalias", 1'b0, 32'h1000_0017, 32'h0, rd, oa);
      check("rdalias_data", 64'(rd), 64'hA5A50001);
      repeat (3) @(negedge clock);
      check("rdata_hold", 64'(rdata), 64'hA5A50001);

      // input ports
      in_port = {32'hCAFEF00D, 32'h12345678};
      repeat (3) @(negedge clock);
      access("rdin0", 1'b0, 32'h80, 32'h0, rd, oa);
      check("rdin0_data", 64'(rd), 64'h12345678);
      check("rdin0_err", 64'(err), 64'd0);
      access("rdin1", 1'b0, 32'h84, 32'h0, rd, oa);
      check("rdin1_data", 64'(rd), 64'hCAFEF00D);

      // synchroniser: a change just before the read is not yet visible
      in_port[31:0] = 32'h9ABCDEF0;
      access("rdsync_old", 1'b0, 32'h80, 32'h0, rd, oa);
      check("rdsync_old_data", 64'(rd), 64'h12345678);
      access("rdsync_new", 1'b0, 32'h80, 32'h0, rd, oa);
      check("rdsync_new_data", 64'(rd), 64'h9ABCDEF0);

      // output ports and read-back
      access("wrout1", 1'b1, 32'h84, 32'h5, rd, oa);
      check("wrout1_acc_edge", oa, 64'h00000005_00000000);
      access("rbout1", 1'b0, 32'h8C, 32'h0, rd, oa);
      check("rbout1_data", 64'(rd), 64'h5);
      access("rbout0", 1'b0, 32'h88, 32'h0, rd, oa);
      check("rbout0_zero", 64'(rd), 64'h0);
      access("wrout0", 1'b1, 32'h80, 32'h1111, rd, oa);
      access("rbout0b", 1'b0, 32'h88, 32'h0, rd, oa);
      check("rbout0b_data", 64'(rd), 64'h1111);

      // out-of-range I/O write and read
      check("err_before", 64'(err), 64'd0);
      access("wroor", 1'b1, 32'hFC, 32'hFFFF, rd, oa);
      check("wroor_out", out_port, 64'h00000005_00001111);
      check("wroor_err", 64'(err), 64'd1);
      access("rdoor", 1'b0, 32'h90, 32'h0, rd, oa);
      check("rdoor_zero", 64'(rd), 64'h0);
      access("rdok", 1'b0, 32'h10, 32'h0, rd, oa);
      check("err_sticky", 64'(err), 64'd1);

      // req held through DONE: second write lands only in the next IDLE
      req = 1'b1; we = 1'b1; addr = 32'h84; wdata = 32'h7;
      @(posedge clock);
      #1 wdata = 32'h9;
      @(negedge clock);
      check("b2b_rdy1", 64'(ready), 64'd1);
      check("b2b_out7", out_port, 64'h00000007_00001111);
      @(negedge clock);
      check("b2b_done_ign_rdy", 64'(ready), 64'd0);
      check("b2b_done_ign_out", out_port, 64'h00000007_00001111);
      @(posedge clock);
      #1 req = 1'b0; we = 1'b0;
      @(negedge clock);
      check("b2b_rdy2", 64'(ready), 64'd1);
      check("b2b_out9", out_port, 64'h00000009_00001111);
      @(negedge clock);

      // reset during WAIT of a read
      req = 1'b1; we = 1'b0; addr = 32'h8C;
      @(posedge clock);
      #1 req = 1'b0;
      check("rstw_in_wait", 64'(ready), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("rstw_ready", 64'(ready), 64'd0);
      check("rstw_out",   out_port,   64'd0);
      check("rstw_err",   64'(err),   64'd0);
      check("rstw_rdata", 64'(rdata), 64'd0);
      @(negedge clock);
      check("rstw_ready2", 64'(ready), 64'd0);
      reset = 1'b0;
      access("rdpost", 1'b0, 32'h10, 32'h0, rd, oa);
      check("rdpost_data", 64'(rd), 64'hDEADBEEF);

      // reset in DONE of a write: the RAM write stays
      req = 1'b1; we = 1'b1; addr = 32'h18; wdata = 32'h600DCAFE;
      @(posedge clock);
      #1 req = 1'b0; we = 1'b0; reset = 1'b1;
      #1 check("rstd_ready", 64'(ready), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      access("rd18", 1'b0, 32'h18, 32'h0, rd, oa);
      check("rd18_data", 64'(rd), 64'h600DCAFE);

`ifdef MC_IOMEM_WSTRB_EN
      wstrb = 4'hF;
      access("wsfull", 1'b1, 32'h20, 32'hFFFFFFFF, rd, oa);
      wstrb = 4'b0011;
      access("wspart", 1'b1, 32'h20, 32'h00000000, rd, oa);
      wstrb = 4'hF;
      access("rdws", 1'b0, 32'h20, 32'h0, rd, oa);
      check("rdws_data", 64'(rd), 64'hFFFF0000);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_iomem_ctrl.md
MC_IOMEM_CTRL -- requirements
Module: mc_iomem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 32: data RAM depth in words; SHALL be a power of two, 2..32.
REQ-003 Parameter N_IN, default 2: input port count, 1..32.
REQ-004 Parameter N_OUT, default 2: output port count, 1..32.
REQ-005 Parameter RD_WAIT, default 1: extra wait cycles on every read, 0..7.
REQ-006 clock  in  1: single clock; all state SHALL change on its rising edge.
REQ-007 reset  in  1: asynchronous, active-high reset.
REQ-008 req  in  1: access request, sampled only in IDLE.
REQ-009 we  in  1: 1 = write, 0 = read; sampled with req.
REQ-010 addr  in  32: byte address; bits [1:0] ignored.
REQ-011 wdata  in  DATA_W: write data.
REQ-012 rdata  out  DATA_W: read data, valid while ready=1.
REQ-013 ready  out  1: one-cycle completion pulse.
REQ-014 err  out  1: sticky flag for out-of-range I/O access.
REQ-015 in_port  in  N_IN*DATA_W: input ports; port i occupies bits [i*DATA_W +: DATA_W].
REQ-016 out_port  out  N_OUT*DATA_W: registered output ports, packed the same way.

Function
REQ-017 Address map: addr[7]=0 selects RAM word addr[log2(DEPTH)+1:2]; addr[7]=1 selects I/O index addr[6:2]; addr[31:8] is ignored.
REQ-018 FSM states: IDLE, WAIT, DONE; IDLE with req=1 SHALL latch addr, we and wdata and accept the access.
REQ-019 Accepted write: target SHALL update on the accepting edge; next state DONE; ready=1 exactly one cycle after acceptance.
REQ-020 Accepted read with RD_WAIT>0: go to WAIT for RD_WAIT cycles, then DONE; ready=1 exactly RD_WAIT+1 cycles after acceptance.
REQ-021 Accepted read with RD_WAIT=0: go directly to DONE; ready=1 one cycle after acceptance.
REQ-022 DONE SHALL last exactly one cycle and return to IDLE; a back-to-back req is accepted in the following IDLE cycle, not in DONE.
REQ-023 req asserted in WAIT or DONE SHALL be ignored; latched fields SHALL NOT change during an access.
REQ-024 rdata SHALL hold its last value outside DONE; for a write, rdata is unchanged.
REQ-025 I/O read at index i<N_IN SHALL return in_port i through a two-flop synchroniser, i.e. the value sampled two edges before the read data is captured.
REQ-026 I/O write at index i<N_OUT SHALL load out_port i; I/O read at index i with N_IN<=i<N_IN+N_OUT SHALL read back out_port (i-N_IN).
REQ-027 I/O write at index >=N_OUT, or I/O read at index >=N_IN+N_OUT: the write is discarded, the read returns 0, err is set to 1, and ready still pulses.
REQ-028 RAM is a DEPTH x DATA_W array; a RAM read SHALL return the contents at the time the read data is captured, including a write completed in the immediately preceding access.

Reset
REQ-029 While reset=1: state=IDLE, ready=0, rdata=0, err=0, out_port=0, synchroniser flops=0; RAM contents are not reset.
REQ-030 Reset asserted mid-access SHALL abort it with no ready pulse; a write already committed on its accepting edge SHALL remain in RAM.
REQ-031 err SHALL clear only on reset.

Configuration
REQ-032 With macro MC_IOMEM_WSTRB_EN defined, an input wstrb (DATA_W/8 bits) SHALL exist, sampled with req, and RAM and out_port writes SHALL update only bytes whose strobe bit is 1.
REQ-033 Without MC_IOMEM_WSTRB_EN, the wstrb port SHALL be absent and every write SHALL be full-word.

Verification
REQ-034 RD_WAIT=1: write 0xDEADBEEF to addr 0x10, then read 0x10 -> ready 1 cycle after write acceptance; on the read, ready 2 cycles after acceptance with rdata=0xDEADBEEF.
REQ-035 in_port0=0x12345678 held for 3 cycles, then read addr 0x80 -> rdata=0x12345678, err=0.
REQ-036 Write 0x5 to addr 0x84 -> out_port1=0x5 on the accepting edge; read addr 0x8C (N_IN=2) -> rdata=0x5.
REQ-037 Write to addr 0xFC -> no port changes, err=1, ready pulses; err stays 1 until reset.
REQ-038 reset asserted in WAIT during a read -> no ready pulse, out_port=0, next req accepted normally.
REQ-039 MC_IOMEM_WSTRB_EN defined: RAM word 0xFFFFFFFF, write 0x00000000 with wstrb=4'b0011 -> read returns 0xFFFF0000.
